// File: rtl/alu_seq_ctrl_if.sv
// Requester / response bus for the bit-serial ALU sequencer.
// master: the side that issues operations and consumes results.
// slave:  the sequencer itself.
interface alu_seq_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [1:0]       req0_s;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [1:0]       req1_s;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_id;

    modport master (
        output req0_valid, req0_a, req0_b, req0_s,
        output req1_valid, req1_a, req1_b, req1_s,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_s,
        input  req1_valid, req1_a, req1_b, req1_s,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_data, rsp_id
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Two-requester sequencer for a shared 1-bit logic cell. An accepted
// operation is streamed through the cell LSB first, one bit per cycle,
// and the assembled word is presented on the response channel.
module alu_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_seq_ctrl_if.slave bus,
    output logic          cl_a,
    output logic          cl_b,
    output logic [1:0]    cl_s,
    input  logic          cl_out
);
    localparam int KW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [KW-1:0]    k_q;
    logic             prio_q;      // 0: req0 wins a tie, 1: req1 wins a tie
    logic             id_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       s_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] rsp_data_q;
    logic             rsp_id_q;
    logic             grant0;
    logic             grant1;
    logic             last_bit;

    // Next state, arbitration, cell drive and result bit insertion
    always_comb begin
        state_d  = state_q;
        grant0   = 1'b0;
        grant1   = 1'b0;
        cl_a     = 1'b0;
        cl_b     = 1'b0;
        cl_s     = 2'b00;
        res_d    = res_q;
        last_bit = (k_q == KW'(WIDTH - 1));
        case (state_q)
            IDLE: begin
                if (bus.req0_valid && (!bus.req1_valid || !prio_q)) begin
                    grant0 = 1'b1;
                end else if (bus.req1_valid) begin
                    grant1 = 1'b1;
                end
                if (grant0 || grant1) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                cl_a       = a_q[k_q];
                cl_b       = b_q[k_q];
                cl_s       = s_q;
                res_d[k_q] = cl_out;
                if (last_bit) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Ready is suppressed while reset is held even though the FSM already sits in IDLE
    assign bus.req0_ready = grant0 & rst_n;
    assign bus.req1_ready = grant1 & rst_n;
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_id     = rsp_id_q;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Bit index, tie-break priority, owner id and the published response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q        <= '0;
            prio_q     <= 1'b0;
            id_q       <= 1'b0;
            rsp_data_q <= '0;
            rsp_id_q   <= 1'b0;
        end else if (grant0 || grant1) begin
            k_q    <= '0;
            prio_q <= grant0;
            id_q   <= grant1;
        end else if (state_q == RUN) begin
            k_q <= k_q + KW'(1);
            if (last_bit) begin
                rsp_data_q <= res_d;
                rsp_id_q   <= id_q;
            end
        end
    end

    // Operand capture on accept and partial result; these never need a reset value
    always_ff @(posedge clk) begin
        if (grant1) begin
            a_q <= bus.req1_a;
            b_q <= bus.req1_b;
            s_q <= bus.req1_s;
        end else if (grant0) begin
            a_q <= bus.req0_a;
            b_q <= bus.req0_b;
            s_q <= bus.req0_s;
        end
        res_q <= res_d;
    end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl with an XOR logic cell and WIDTH=4.
// A transaction-level model predicts grants, timing and results; a
// negedge monitor compares the DUT against it.
module tb_alu_seq_ctrl;
    localparam int W = 4;

    logic       clk;
    logic       rst_n;
    logic       cl_a;
    logic       cl_b;
    logic [1:0] cl_s;
    logic       cl_out;

    alu_seq_ctrl_if #(.WIDTH(W)) bus ();

    alu_seq_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .cl_a   (cl_a),
        .cl_b   (cl_b),
        .cl_s   (cl_s),
        .cl_out (cl_out)
    );

    assign cl_out = cl_a ^ cl_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // ---------------- reference model state ----------------
    typedef struct {
        bit         id;
        logic [W-1:0] data;
    } exp_t;

    exp_t         exp_q[$];
    bit           m_busy = 0;
    bit           m_prio = 0;
    int           m_acc  = 0;
    logic [W-1:0] m_a, m_b, m_last;
    logic [1:0]   m_s;
    int           cyc = 0;
    int           acc_cyc[$];
    bit           acc_id[$];
    bit           rsp_ids[$];
    int           rr_mode = 0;   // 0: rsp_ready=1, 1: random, 2: rsp_ready=0

    initial m_last = '0;

    // Monitor: predicts and checks everything the DUT shows at each negedge
    always @(negedge clk) begin
        bit           v0, v1, g0, g1, ev, inrun, win;
        int           k;
        logic [3:0]   ecl;
        if (!rst_n) begin
            m_busy = 0;
            m_prio = 0;
            m_last = '0;
            exp_q.delete();
        end else begin
            cyc++;
            v0 = bus.req0_valid;
            v1 = bus.req1_valid;
            g0 = 0;
            g1 = 0;
            if (!m_busy && (v0 || v1)) begin
                win = (v0 && v1) ? m_prio : v1;
                g0  = !win;
                g1  = win;
            end
            check("ready", {bus.req1_ready, bus.req0_ready}, {g1, g0});
            if ((bus.req0_ready && v0) || (bus.req1_ready && v1)) begin
                acc_cyc.push_back(cyc);
                acc_id.push_back(bus.req1_ready);
            end

            inrun = m_busy && (cyc > m_acc) && (cyc <= m_acc + W);
            k     = cyc - m_acc - 1;
            ecl   = inrun ? {m_a[k], m_b[k], m_s} : 4'b0000;
            check("cl_ports", {cl_a, cl_b, cl_s}, ecl);

            ev = m_busy && (cyc >= m_acc + W + 1);
            check("rsp_valid", bus.rsp_valid, ev);
            if (ev && exp_q.size() > 0) begin
                check("rsp_data", bus.rsp_data, exp_q[0].data);
                check("rsp_id", bus.rsp_id, exp_q[0].id);
                if (bus.rsp_ready) begin
                    m_last = exp_q[0].data;
                    rsp_ids.push_back(bus.rsp_id);
                    void'(exp_q.pop_front());
                    m_busy = 0;
                end
            end else if (!ev) begin
                check("rsp_hold", bus.rsp_data, m_last);
            end

            if (g0 || g1) begin
                exp_t e;
                m_busy = 1;
                m_acc  = cyc;
                m_a    = g1 ? bus.req1_a : bus.req0_a;
                m_b    = g1 ? bus.req1_b : bus.req0_b;
                m_s    = g1 ? bus.req1_s : bus.req0_s;
                m_prio = g0;
                e.id   = g1;
                e.data = m_a ^ m_b;
                exp_q.push_back(e);
            end
        end
    end

    // Response-side ready generator
    initial begin
        bus.rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                0:       bus.rsp_ready = 1'b1;
                1:       bus.rsp_ready = 1'($urandom_range(0, 1));
                default: bus.rsp_ready = 1'b0;
            endcase
        end
    end

    task automatic issue(input bit id, input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] s);
        bit got;
        got = 0;
        if (id) begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_s = s; bus.req1_valid = 1'b1;
        end else begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_s = s; bus.req0_valid = 1'b1;
        end
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rst_n && (id ? bus.req1_ready : bus.req0_ready)) begin
                got = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        // operands scrubbed right after accept; the result must not notice
        if (id) begin
            bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_s = '0;
        end else begin
            bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_s = '0;
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: requester %0d never accepted", id);
        end
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #2;
            if (!m_busy && exp_q.size() == 0 && !bus.rsp_valid) begin
                done = 1;
                break;
            end
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_timeout: busy=%0d pending=%0d", m_busy, exp_q.size());
        end
    endtask

    task automatic check_reset(input string nm);
        check(nm, {bus.req0_ready, bus.req1_ready, bus.rsp_valid, bus.rsp_data,
                   bus.rsp_id, cl_a, cl_b, cl_s}, 32'd0);
    endtask

    task automatic stream(input bit id, input int n, input int max_gap);
        for (int i = 0; i < n; i++) begin
            issue(id, W'($urandom), W'($urandom), 2'($urandom));
            if (max_gap > 0) begin
                repeat ($urandom_range(0, max_gap)) @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.req0_valid = 0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_s = '0;
        bus.req1_valid = 0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_s = '0;

        // contention from reset: both valid while reset is held
        fork
            issue(0, 4'b1010, 4'b0110, 2'b10);
            issue(1, 4'b0011, 4'b0101, 2'b01);
            begin
                #3;
                check_reset("reset_state");
                repeat (3) @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
        join
        wait_idle();
        fork
            issue(0, 4'b1100, 4'b0101, 2'b11);
            issue(1, 4'b0110, 4'b0110, 2'b00);
        join
        wait_idle();
        check("contention_len", rsp_ids.size(), 4);
        if (rsp_ids.size() >= 3) begin
            check("contention_id0", rsp_ids[0], 0);
            check("contention_id1", rsp_ids[1], 1);
            check("contention_id2", rsp_ids[2], 0);
        end

        // single op with known answer
        issue(0, 4'b1010, 4'b0110, 2'b10);
        wait_idle();
        check("single_data", bus.rsp_data, 4'b1100);
        check("single_id", bus.rsp_id, 0);

        // backpressure in RESP with req1 waiting
        rr_mode = 2;
        @(posedge clk);
        #1;
        fork
            begin
                issue(0, 4'b0111, 4'b1001, 2'b01);
                repeat (W + 5) @(posedge clk);
                rr_mode = 0;
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                issue(1, 4'b1000, 4'b0001, 2'b10);
            end
        join
        wait_idle();

        // operand change right after accept
        issue(1, 4'b1111, 4'b0000, 2'b01);
        wait_idle();
        check("opchg_data", bus.rsp_data, 4'b1111);
        check("opchg_id", bus.rsp_id, 1);

        // reset in the middle of RUN
        issue(0, 4'b0101, 4'b0011, 2'b11);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset("reset_midrun");
        @(posedge clk);
        #1;
        check_reset("reset_held");
        rst_n = 1'b1;
        rsp_ids.delete();
        fork
            issue(1, 4'b1110, 4'b0100, 2'b10);
            issue(0, 4'b0001, 4'b1011, 2'b01);
        join
        wait_idle();
        check("post_reset_len", rsp_ids.size(), 2);
        if (rsp_ids.size() == 2) begin
            check("post_reset_id0", rsp_ids[0], 0);
            check("post_reset_id1", rsp_ids[1], 1);
        end

        // throughput: both requesters continuously valid
        acc_cyc.delete();
        acc_id.delete();
        fork
            stream(0, 6, 0);
            stream(1, 6, 0);
        join
        wait_idle();
        check("tput_count", acc_cyc.size(), 12);
        for (int i = 1; i < acc_cyc.size(); i++) begin
            check("tput_period", acc_cyc[i] - acc_cyc[i-1], W + 2);
            check("tput_alternate", acc_id[i], !acc_id[i-1]);
        end

        // random traffic with random response backpressure
        rr_mode = 1;
        fork
            stream(0, 10, 8);
            stream(1, 10, 8);
        join
        rr_mode = 0;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
